// File: rtl/ber_test_controller.sv
// Bit-error-ratio test controller: PRBS/user source, loopback compare, saturating bit/error counters.
// Optional error injection on tx_data is enabled with `define BER_ERR_INJ_EN.
//
// state | meaning
// IDLE  | waiting for start, tx_data = 0, LFSR holds
// WARM  | LOOP_LAT cycles filling the expected-data delay line, no compares
// RUN   | compare rx_data against delayed tx on every rx_valid cycle
// DONE  | counters frozen for readout, start re-arms
module ber_test_controller #(
  parameter int                DATA_W   = 8,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] POLY     = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  parameter int                LOOP_LAT = 2,
  parameter int                CNT_W    = 32,
  parameter int                ERR_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              sel,
  input  logic [DATA_W-1:0] normal_input,
  input  logic [CNT_W-1:0]  bit_target,
`ifdef BER_ERR_INJ_EN
  input  logic              inj_strobe,
  input  logic [DATA_W-1:0] inj_mask,
`endif
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] error,
  output logic [ERR_W-1:0]  total_error,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  localparam int PC_W = $clog2(DATA_W + 1);
  localparam int WC_W = (LOOP_LAT > 1) ? $clog2(LOOP_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WARM = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                     state;
  logic [LFSR_W-1:0]              lfsr;
  logic [LFSR_W-1:0]              lfsr_walk;
  logic [DATA_W-1:0]              lfsr_word;
  logic [DATA_W-1:0]              tx_word;
  logic [DATA_W-1:0]              tx_clean;
  logic [DATA_W-1:0]              inj_word;
  logic [LOOP_LAT-1:0][DATA_W-1:0] dly;
  logic [WC_W-1:0]                warm_cnt;
  logic [DATA_W-1:0]              err_word;
  logic [PC_W-1:0]                err_pop;
  logic [ERR_W:0]                 err_sum;
  logic [CNT_W:0]                 cnt_sum;
  logic [ERR_W-1:0]               err_next;
  logic [CNT_W-1:0]               cnt_next;
  logic [CNT_W-1:0]               cnt_upd;
  logic                           do_cmp;
  logic                           hit_target;

  // DATA_W serial Galois shifts per cycle, first shifted-out bit lands in bit 0
  always_comb begin
    lfsr_walk = lfsr;
    lfsr_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      lfsr_word[i] = lfsr_walk[0];
      lfsr_walk    = (lfsr_walk >> 1) ^ (lfsr_word[i] ? POLY : {LFSR_W{1'b0}});
    end
  end

  assign tx_word = sel ? lfsr_word : normal_input;

`ifdef BER_ERR_INJ_EN
  assign inj_word = (state == S_RUN && inj_strobe) ? inj_mask : '0;
`else
  assign inj_word = '0;
`endif

  always_comb begin
    err_word = rx_data ^ dly[LOOP_LAT-1];
    err_pop  = '0;
    for (int i = 0; i < DATA_W; i++)
      err_pop = err_pop + {{(PC_W-1){1'b0}}, err_word[i]};
  end

  assign do_cmp     = (state == S_RUN) && rx_valid;
  assign err_sum    = {1'b0, total_error} + (ERR_W+1)'(err_pop);
  assign cnt_sum    = {1'b0, count} + (CNT_W+1)'(DATA_W);
  assign err_next   = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  assign cnt_next   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  assign cnt_upd    = do_cmp ? cnt_next : count;
  assign hit_target = (bit_target != '0) && (cnt_upd >= bit_target);
  assign busy       = (state == S_WARM) || (state == S_RUN);

  // Delay line carries the uncorrupted word so injected errors are visible
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dly <= '0;
    end else if (busy) begin
      for (int i = LOOP_LAT - 1; i > 0; i--)
        dly[i] <= dly[i-1];
      dly[0] <= tx_clean;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      lfsr        <= SEED;
      tx_data     <= '0;
      tx_clean    <= '0;
      error       <= '0;
      total_error <= '0;
      count       <= '0;
      done        <= 1'b0;
      sat         <= 1'b0;
      warm_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          tx_data  <= '0;
          tx_clean <= '0;
          if (start) begin
            state       <= S_WARM;
            lfsr        <= SEED;
            error       <= '0;
            total_error <= '0;
            count       <= '0;
            sat         <= 1'b0;
            warm_cnt    <= '0;
          end
        end
        S_WARM: begin
          tx_data  <= tx_word ^ inj_word;
          tx_clean <= tx_word;
          lfsr     <= lfsr_walk;
          warm_cnt <= warm_cnt + WC_W'(1);
          if (stop) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (warm_cnt == WC_W'(LOOP_LAT - 1)) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          tx_data  <= tx_word ^ inj_word;
          tx_clean <= tx_word;
          lfsr     <= lfsr_walk;
          if (do_cmp) begin
            error       <= err_word;
            total_error <= err_next;
            count       <= cnt_next;
            if (err_sum[ERR_W] || cnt_sum[CNT_W])
              sat <= 1'b1;
          end
          if (stop || hit_target) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ber_test_controller.sv
// Bench for ber_test_controller: spec-level model with per-cycle compare, plus directed literal checks.
// Two DUTs share stimulus; the second uses ERR_W=4 to exercise error-counter saturation.
module tb_ber_test_controller;
  localparam int          DATA_W   = 8;
  localparam int          LOOP_LAT = 2;
  localparam int          CNT_W    = 32;
  localparam logic [15:0] POLY     = 16'hB400;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam longint      EMAX1    = 65535;
  localparam longint      EMAX2    = 15;
  localparam longint      CMAX     = 64'hFFFF_FFFF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              sel = 1'b1;
  logic [DATA_W-1:0] normal_input = '0;
  logic [CNT_W-1:0]  bit_target = '0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid = 1'b1;
  logic              inj_strobe = 1'b0;
  logic [DATA_W-1:0] inj_mask = '0;
  logic [DATA_W-1:0] tx_data, tx_data2, error, error2;
  logic [15:0]       total_error;
  logic [3:0]        total_error2;
  logic [CNT_W-1:0]  count, count2;
  logic              busy, busy2, done, done2, sat, sat2;

  logic              rx_inv = 1'b0;
  logic [DATA_W-1:0] rx_flip = '0;
  logic [DATA_W-1:0] ch0, ch1;
  logic              chk_en = 1'b0;
  int                n_tests = 0;
  int                n_fail = 0;

  always #5 clock = ~clock;

  ber_test_controller dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .sel(sel),
    .normal_input(normal_input), .bit_target(bit_target),
`ifdef BER_ERR_INJ_EN
    .inj_strobe(inj_strobe), .inj_mask(inj_mask),
`endif
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .error(error),
    .total_error(total_error), .count(count), .busy(busy), .done(done), .sat(sat)
  );

  ber_test_controller #(.ERR_W(4)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .sel(sel),
    .normal_input(normal_input), .bit_target(bit_target),
`ifdef BER_ERR_INJ_EN
    .inj_strobe(inj_strobe), .inj_mask(inj_mask),
`endif
    .tx_data(tx_data2), .rx_data(rx_data), .rx_valid(rx_valid), .error(error2),
    .total_error(total_error2), .count(count2), .busy(busy2), .done(done2), .sat(sat2)
  );

  // Channel: two-cycle loopback with optional full inversion or bit flips
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ch0 <= '0;
      ch1 <= '0;
    end else begin
      ch0 <= tx_data;
      ch1 <= ch0;
    end
  end
  assign rx_data = rx_inv ? ~ch1 : (ch1 ^ rx_flip);

  // Model: states by name, unbounded counters clipped only when compared
  typedef enum {M_IDLE, M_WARM, M_RUN, M_DONE} mstate_t;
  mstate_t           m_st;
  logic [15:0]       m_lfsr;
  logic [DATA_W-1:0] m_tx, m_txc, m_err;
  logic [DATA_W-1:0] m_hist[$];
  longint            m_tot, m_cnt;
  int                m_warm;
  logic              m_done;

  function automatic logic [DATA_W-1:0] prbs_next();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W; i++) begin
      w[i]   = m_lfsr[0];
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ POLY) : (m_lfsr >> 1);
    end
    return w;
  endfunction

  always @(posedge clock or negedge reset) begin
    logic [DATA_W-1:0] exp_w, w, inj, e;
    if (!reset) begin
      m_st = M_IDLE; m_lfsr = SEED; m_tx = '0; m_txc = '0; m_err = '0;
      m_tot = 0; m_cnt = 0; m_warm = 0; m_done = 1'b0;
      m_hist.delete();
      for (int i = 0; i < LOOP_LAT; i++) m_hist.push_back('0);
    end else begin
      m_done = 1'b0;
      if (m_st == M_IDLE || m_st == M_DONE) begin
        m_tx = '0; m_txc = '0;
        if (start) begin
          m_st = M_WARM; m_lfsr = SEED; m_err = '0;
          m_tot = 0; m_cnt = 0; m_warm = 0;
        end
      end else begin
        exp_w = m_hist[0];
        if (m_st == M_RUN && rx_valid) begin
          e = rx_data ^ exp_w;
          m_err = e;
          m_tot += $countones(e);
          m_cnt += DATA_W;
        end
        m_hist.push_back(m_txc);
        void'(m_hist.pop_front());
        w = sel ? prbs_next() : normal_input;
        inj = '0;
`ifdef BER_ERR_INJ_EN
        if (m_st == M_RUN && inj_strobe) inj = inj_mask;
`endif
        m_txc = w;
        m_tx = w ^ inj;
        if (m_st == M_WARM) begin
          m_warm++;
          if (stop) begin m_st = M_DONE; m_done = 1'b1; end
          else if (m_warm == LOOP_LAT) m_st = M_RUN;
        end else if (stop || (bit_target != 0 && m_cnt >= longint'(bit_target))) begin
          m_st = M_DONE; m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("tx_data", 64'(tx_data), 64'(m_tx));
      chk("tx_data2", 64'(tx_data2), 64'(m_tx));
      chk("busy", 64'(busy), 64'(m_st == M_WARM || m_st == M_RUN));
      chk("done", 64'(done), 64'(m_done));
      chk("done2", 64'(done2), 64'(m_done));
      chk("error", 64'(error), 64'(m_err));
      chk("count", 64'(count), 64'((m_cnt > CMAX) ? CMAX : m_cnt));
      chk("total_error", 64'(total_error), 64'((m_tot > EMAX1) ? EMAX1 : m_tot));
      chk("total_error2", 64'(total_error2), 64'((m_tot > EMAX2) ? EMAX2 : m_tot));
      chk("sat", 64'(sat), 64'(m_tot > EMAX1 || m_cnt > CMAX));
      chk("sat2", 64'(sat2), 64'(m_tot > EMAX2 || m_cnt > CMAX));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int k = 0; k < max && !done; k++) cyc(1);
    chk("wait_done", 64'(done), 64'd1);
  endtask

  initial begin
    int nb, nd;
    logic [DATA_W-1:0] w1, w2;
    nb = 0; nd = 0; w1 = '0; w2 = '0;

    cyc(2);
    chk("rst_tx", 64'(tx_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Ideal PRBS loopback to a 64-bit target
    bit_target = 64;
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      if (busy) nb++;
      if (done) nd++;
      if (k == 1) w1 = tx_data;
      if (k == 2) w2 = tx_data;
      cyc(1);
    end
    chk("busy_cycles", 64'(nb), 64'd10);
    chk("done_pulses", 64'(nd), 64'd1);
    chk("prbs_w0", 64'(w1), 64'hE1);
    chk("prbs_w1", 64'(w2), 64'hC4);
    chk("count_64", 64'(count), 64'd64);
    chk("tot_zero", 64'(total_error), 64'd0);

    // Open-ended run stopped after five RUN cycles, then restart
    bit_target = 0;
    pulse_start();
    cyc(6);
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("stop_done", 64'(done), 64'd1);
    chk("count_40", 64'(count), 64'd40);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(1);
    chk("stop_in_done_busy", 64'(busy), 64'd0);
    chk("stop_in_done_cnt", 64'(count), 64'd40);
    pulse_start();
    chk("restart_cnt", 64'(count), 64'd0);
    cyc(1);
    chk("restart_w0", 64'(tx_data), 64'hE1);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(2);

    // Inverted channel: narrow error counter clips and sets sat
    bit_target = 16;
    rx_inv = 1'b1;
    pulse_start();
    wait_done(20);
    chk("inv_tot16", 64'(total_error), 64'd16);
    chk("inv_tot2_clip", 64'(total_error2), 64'd15);
    chk("inv_sat2", 64'(sat2), 64'd1);
    chk("inv_sat", 64'(sat), 64'd0);
    rx_inv = 1'b0;
    bit_target = 8;
    pulse_start();
    chk("sat2_cleared", 64'(sat2), 64'd0);
    wait_done(20);

    // User traffic with one flipped bit and an rx_valid gap
    sel = 1'b0;
    bit_target = 0;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      normal_input = DATA_W'(k);
      rx_valid = !(k >= 10 && k < 13);
      rx_flip = (k == 8) ? 8'h04 : 8'h00;
      cyc(1);
    end
    rx_valid = 1'b1;
    rx_flip = '0;
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("user_tot1", 64'(total_error), 64'd1);
    chk("user_count", 64'(count), 64'd96);
    sel = 1'b1;
    cyc(2);

`ifdef BER_ERR_INJ_EN
    // Injection: three single-bit words then one full-word corruption
    pulse_start();
    cyc(2);
    inj_strobe = 1'b1;
    inj_mask = 8'h01;
    cyc(3);
    inj_mask = 8'hFF;
    cyc(1);
    inj_strobe = 1'b0;
    inj_mask = '0;
    cyc(3);
    chk("inj_error_ff", 64'(error), 64'hFF);
    chk("inj_tot11", 64'(total_error), 64'd11);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(2);
`endif

    // Asynchronous reset in the middle of RUN
    pulse_start();
    cyc(5);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_tx", 64'(tx_data), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_error", 64'(error), 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
